// File: rtl/rx_data_receive.sv
// Receive-side SpaceWire character handler: ESC resolution, FIFO writes, time-codes, credit tracking.
// Optional macro RX_TCODE_SEQ_CHECK_EN: tick only when time[5:0] follows the previous one by +1 mod 64.
module rx_data_receive #(
  parameter int unsigned MAX_CREDIT  = 56,
  parameter int unsigned CREDIT_STEP = 8
) (
  input  logic       pclk_rx,
  input  logic       enable_rx,
  input  logic       link_run,
  input  logic       rx_char_valid,
  input  logic       rx_char_ctrl,
  input  logic [7:0] rx_char,
  input  logic       rx_parity_err,
  input  logic       fct_sent,
  input  logic       fct_taken,
  output logic [8:0] rx_data_o,
  output logic       rx_data_wr,
  output logic [7:0] timecode_rx_o,
  output logic       tick_out,
  output logic       got_null,
  output logic       got_fct,
  output logic       got_nchar,
  output logic [5:0] fct_counter_p,
  output logic       err_parity,
  output logic       err_esc,
  output logic       err_credit
);

  localparam logic [6:0] MAX_C  = 7'(MAX_CREDIT);
  localparam logic [6:0] STEP_C = 7'(CREDIT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_ESC, S_ERR} state_e;

  state_e     state_q, state_d;
  logic [5:0] rx_credit_q, rx_credit_d;
  logic [5:0] fct_cnt_q, fct_cnt_d;
  logic [8:0] rx_data_q, rx_data_d;
  logic [7:0] tcode_q, tcode_d;
  logic       rx_wr_q, rx_wr_d;
  logic       tick_q, tick_d;
  logic       null_q, null_d;
  logic       fct_q, fct_d;
  logic       nchar_q, nchar_d;
  logic       err_par_q, err_par_d;
  logic       err_esc_q, err_esc_d;
  logic       err_cred_q, err_cred_d;

  logic       ch_ok, dec, in_idle, in_esc;
  logic       is_fct, is_eop, is_esc;
  logic       par_hit, nchar_req, nchar_ev, nchar_err;
  logic       fct_rx, fct_ovf, null_ev, tcode_ev, esc_err, go_err, tcode_seq_ok;
  logic [6:0] fct_net, rx_sum;

  // Character decode shared by the next-state and output logic
  always_comb begin
    ch_ok     = link_run && rx_char_valid && (state_q != S_ERR);
    par_hit   = ch_ok && rx_parity_err;
    dec       = ch_ok && !rx_parity_err;
    in_idle   = (state_q == S_IDLE);
    in_esc    = (state_q == S_ESC);
    is_fct    = rx_char_ctrl && (rx_char[1:0] == 2'b00);
    is_eop    = rx_char_ctrl && (rx_char[1:0] == 2'b01);
    is_esc    = rx_char_ctrl && (rx_char[1:0] == 2'b11);
    nchar_req = dec && in_idle && !is_fct && !is_esc;
    nchar_ev  = nchar_req && (rx_credit_q != 6'd0);
    nchar_err = nchar_req && (rx_credit_q == 6'd0);
    fct_rx    = dec && in_idle && is_fct;
    fct_net   = {1'b0, fct_cnt_q} + STEP_C - {6'd0, fct_taken};
    fct_ovf   = fct_rx && (fct_net > MAX_C);
    null_ev   = dec && in_esc && is_fct;
    tcode_ev  = dec && in_esc && !rx_char_ctrl;
    esc_err   = dec && in_esc && rx_char_ctrl && !is_fct;
    go_err    = par_hit || esc_err || nchar_err || fct_ovf;
    rx_sum    = {1'b0, rx_credit_q} + (fct_sent ? STEP_C : 7'd0) - {6'd0, nchar_ev};
`ifdef RX_TCODE_SEQ_CHECK_EN
    tcode_seq_ok = (rx_char[5:0] == 6'(tcode_q[5:0] + 6'd1));
`else
    tcode_seq_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    if (!link_run)                state_d = S_IDLE;
    else if (go_err)              state_d = S_ERR;
    else if (dec && in_idle && is_esc) state_d = S_ESC;
    else if (null_ev || tcode_ev) state_d = S_IDLE;
  end

  always_comb begin
    rx_data_d   = rx_data_q;
    tcode_d     = tcode_q;
    rx_wr_d     = 1'b0;
    tick_d      = 1'b0;
    null_d      = 1'b0;
    fct_d       = 1'b0;
    nchar_d     = 1'b0;
    err_par_d   = err_par_q;
    err_esc_d   = err_esc_q;
    err_cred_d  = err_cred_q;
    rx_credit_d = rx_credit_q;
    fct_cnt_d   = fct_cnt_q;
    if (!link_run) begin
      rx_credit_d = '0;
      fct_cnt_d   = '0;
    end else begin
      rx_wr_d    = nchar_ev;
      nchar_d    = nchar_ev;
      null_d     = null_ev;
      fct_d      = fct_rx;
      tick_d     = tcode_ev && tcode_seq_ok;
      err_par_d  = err_par_q | par_hit;
      err_esc_d  = err_esc_q | esc_err;
      err_cred_d = err_cred_q | nchar_err | fct_ovf;
      if (tcode_ev) tcode_d = rx_char;
      if (nchar_ev) begin
        if (!rx_char_ctrl) rx_data_d = {1'b0, rx_char};
        else if (is_eop)   rx_data_d = 9'h100;
        else               rx_data_d = 9'h101;
      end
      rx_credit_d = (rx_sum > MAX_C) ? MAX_C[5:0] : rx_sum[5:0];
      // A rejected (overflowing) FCT still lets a same-cycle fct_taken decrement
      if (fct_rx && !fct_ovf)                   fct_cnt_d = fct_net[5:0];
      else if (fct_taken && fct_cnt_q != 6'd0) fct_cnt_d = fct_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge pclk_rx or negedge enable_rx) begin
    if (!enable_rx) begin
      state_q     <= S_IDLE;
      rx_credit_q <= '0;
      fct_cnt_q   <= '0;
      rx_data_q   <= '0;
      tcode_q     <= '0;
      rx_wr_q     <= 1'b0;
      tick_q      <= 1'b0;
      null_q      <= 1'b0;
      fct_q       <= 1'b0;
      nchar_q     <= 1'b0;
      err_par_q   <= 1'b0;
      err_esc_q   <= 1'b0;
      err_cred_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_credit_q <= rx_credit_d;
      fct_cnt_q   <= fct_cnt_d;
      rx_data_q   <= rx_data_d;
      tcode_q     <= tcode_d;
      rx_wr_q     <= rx_wr_d;
      tick_q      <= tick_d;
      null_q      <= null_d;
      fct_q       <= fct_d;
      nchar_q     <= nchar_d;
      err_par_q   <= err_par_d;
      err_esc_q   <= err_esc_d;
      err_cred_q  <= err_cred_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_data_wr    = rx_wr_q;
  assign timecode_rx_o = tcode_q;
  assign tick_out      = tick_q;
  assign got_null      = null_q;
  assign got_fct       = fct_q;
  assign got_nchar     = nchar_q;
  assign fct_counter_p = fct_cnt_q;
  assign err_parity    = err_par_q;
  assign err_esc       = err_esc_q;
  assign err_credit    = err_cred_q;

endmodule

// File: tb/tb_rx_data_receive.sv
// Bench for rx_data_receive: event-level model checked every cycle, plus directed literal expectations.
module tb_rx_data_receive;

  localparam int MAXC = 56;
  localparam int STEP = 8;
`ifdef RX_TCODE_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic       pclk_rx = 1'b0;
  logic       enable_rx = 1'b0;
  logic       link_run = 1'b0;
  logic       rx_char_valid = 1'b0;
  logic       rx_char_ctrl = 1'b0;
  logic [7:0] rx_char = 8'h00;
  logic       rx_parity_err = 1'b0;
  logic       fct_sent = 1'b0;
  logic       fct_taken = 1'b0;
  logic [8:0] rx_data_o;
  logic       rx_data_wr;
  logic [7:0] timecode_rx_o;
  logic       tick_out, got_null, got_fct, got_nchar;
  logic [5:0] fct_counter_p;
  logic       err_parity, err_esc, err_credit;

  int checks = 0;
  int errors = 0;
  logic [8:0] wr_log[$];

  always #5 pclk_rx = ~pclk_rx;

  rx_data_receive #(.MAX_CREDIT(56), .CREDIT_STEP(8)) dut (
    .pclk_rx(pclk_rx), .enable_rx(enable_rx), .link_run(link_run),
    .rx_char_valid(rx_char_valid), .rx_char_ctrl(rx_char_ctrl), .rx_char(rx_char),
    .rx_parity_err(rx_parity_err), .fct_sent(fct_sent), .fct_taken(fct_taken),
    .rx_data_o(rx_data_o), .rx_data_wr(rx_data_wr), .timecode_rx_o(timecode_rx_o),
    .tick_out(tick_out), .got_null(got_null), .got_fct(got_fct), .got_nchar(got_nchar),
    .fct_counter_p(fct_counter_p), .err_parity(err_parity), .err_esc(err_esc),
    .err_credit(err_credit)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: escape pending / link dead flags and plain integer credit counts
  int         m_rxc = 0, m_txc = 0;
  bit         m_esc = 0, m_dead = 0;
  logic [8:0] m_data = '0;
  logic [7:0] m_tc = '0;
  bit m_wr = 0, m_tick = 0, m_null = 0, m_fct = 0, m_nchar = 0, m_ep = 0, m_ee = 0, m_ec = 0;

  always @(posedge pclk_rx or negedge enable_rx) begin
    int  net;
    bit  took, fct_char;
    if (!enable_rx) begin
      m_rxc = 0; m_txc = 0; m_esc = 0; m_dead = 0; m_data = '0; m_tc = '0;
      m_wr = 0; m_tick = 0; m_null = 0; m_fct = 0; m_nchar = 0; m_ep = 0; m_ee = 0; m_ec = 0;
    end else begin
      m_wr = 0; m_tick = 0; m_null = 0; m_fct = 0; m_nchar = 0;
      took = 0; fct_char = 0;
      if (!link_run) begin
        m_esc = 0; m_dead = 0; m_rxc = 0; m_txc = 0;
      end else begin
        if (rx_char_valid && !m_dead) begin
          if (rx_parity_err) begin
            m_ep = 1; m_dead = 1;
          end else if (m_esc) begin
            m_esc = 0;
            if (!rx_char_ctrl) begin
              m_tick = SEQ ? (int'(rx_char) % 64) == ((int'(m_tc) % 64 + 1) % 64) : 1'b1;
              m_tc = rx_char;
            end else if (rx_char[1:0] == 2'd0) m_null = 1;
            else begin m_ee = 1; m_dead = 1; end
          end else if (rx_char_ctrl && rx_char[1:0] == 2'd3) m_esc = 1;
          else if (rx_char_ctrl && rx_char[1:0] == 2'd0) fct_char = 1;
          else if (m_rxc > 0) begin
            took = 1; m_wr = 1; m_nchar = 1;
            if (!rx_char_ctrl) m_data = {1'b0, rx_char};
            else m_data = (rx_char[1:0] == 2'd1) ? 9'h100 : 9'h101;
          end else begin
            m_ec = 1; m_dead = 1;
          end
        end
        m_rxc = m_rxc + (fct_sent ? STEP : 0) - (took ? 1 : 0);
        if (m_rxc > MAXC) m_rxc = MAXC;
        if (fct_char) begin
          m_fct = 1;
          net = m_txc + STEP - (fct_taken ? 1 : 0);
          if (net > MAXC) begin
            m_ec = 1; m_dead = 1;
            if (fct_taken && m_txc > 0) m_txc--;
          end else m_txc = net;
        end else if (fct_taken && m_txc > 0) m_txc--;
      end
    end
  end

  always @(posedge pclk_rx) begin
    #1;
    if (rx_data_wr === 1'b1) wr_log.push_back(rx_data_o);
    chk("rx_data_o", 32'(rx_data_o), 32'(m_data));
    chk("rx_data_wr", 32'(rx_data_wr), 32'(m_wr));
    chk("timecode_rx_o", 32'(timecode_rx_o), 32'(m_tc));
    chk("tick_out", 32'(tick_out), 32'(m_tick));
    chk("got_null", 32'(got_null), 32'(m_null));
    chk("got_fct", 32'(got_fct), 32'(m_fct));
    chk("got_nchar", 32'(got_nchar), 32'(m_nchar));
    chk("fct_counter_p", 32'(fct_counter_p), 32'(m_txc));
    chk("err_parity", 32'(err_parity), 32'(m_ep));
    chk("err_esc", 32'(err_esc), 32'(m_ee));
    chk("err_credit", 32'(err_credit), 32'(m_ec));
  end

  task automatic cyc(input bit v, input bit c, input logic [7:0] ch,
                     input bit pe = 1'b0, input bit fs = 1'b0, input bit ft = 1'b0);
    rx_char_valid = v; rx_char_ctrl = c; rx_char = ch;
    rx_parity_err = pe; fct_sent = fs; fct_taken = ft;
    @(negedge pclk_rx);
    rx_char_valid = 1'b0; rx_char_ctrl = 1'b0; rx_char = 8'h00;
    rx_parity_err = 1'b0; fct_sent = 1'b0; fct_taken = 1'b0;
  endtask

  task automatic do_reset();
    enable_rx = 1'b0;
    link_run  = 1'b0;
    repeat (2) @(negedge pclk_rx);
    enable_rx = 1'b1;
    link_run  = 1'b1;
    @(negedge pclk_rx);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge pclk_rx);
    chk("reset_fct_counter", 32'(fct_counter_p), 32'd0);
    chk("reset_wr", 32'(rx_data_wr), 32'd0);
    chk("reset_errors", 32'({err_parity, err_esc, err_credit}), 32'd0);
    chk("reset_timecode", 32'(timecode_rx_o), 32'd0);

    // Credit and data write
    enable_rx = 1'b1; link_run = 1'b1;
    @(negedge pclk_rx);
    cyc(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h11 + i));
    chk("write_count", 32'(wr_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("write_data", 32'(wr_log[i]), 32'(9'h011 + i));
    cyc(1, 0, 8'h19);
    chk("credit_err_9th", 32'(err_credit), 32'd1);
    chk("no_write_9th", 32'(wr_log.size()), 32'd8);
    link_run = 1'b0;
    cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
    chk("sticky_after_drop", 32'(err_credit), 32'd1);
    link_run = 1'b1;

    // NULL and time-code
    cyc(1, 1, 8'h03); cyc(1, 1, 8'h00);
    chk("null_pulse", 32'({got_null, got_fct, tick_out}), 32'b100);
    cyc(1, 1, 8'h03); cyc(1, 0, 8'h05);
    chk("tcode_value", 32'(timecode_rx_o), 32'h05);
    chk("tcode_tick", 32'(tick_out), SEQ ? 32'd0 : 32'd1);

    // FCT credit to TX and overflow
    do_reset();
    repeat (7) cyc(1, 1, 8'h00);
    chk("fct_full", 32'(fct_counter_p), 32'd56);
    chk("fct_no_err", 32'(err_credit), 32'd0);
    cyc(1, 1, 8'h00);
    chk("fct_ovf_err", 32'(err_credit), 32'd1);
    chk("fct_ovf_hold", 32'(fct_counter_p), 32'd56);
    repeat (3) cyc(0, 0, 8'h00, 0, 0, 1);
    chk("fct_taken3", 32'(fct_counter_p), 32'd53);

    // Escape error
    do_reset();
    cyc(0, 0, 8'h00, 0, 1, 0);
    n0 = wr_log.size();
    cyc(1, 1, 8'h03); cyc(1, 1, 8'h01);
    chk("esc_err", 32'(err_esc), 32'd1);
    cyc(1, 0, 8'hAA);
    chk("esc_err_absorbs", 32'(wr_log.size()), 32'(n0));

    // Parity error
    do_reset();
    cyc(0, 0, 8'h00, 0, 1, 0);
    n0 = wr_log.size();
    cyc(1, 0, 8'h5A, 1);
    chk("parity_err", 32'(err_parity), 32'd1);
    chk("parity_no_write", 32'(wr_log.size()), 32'(n0));

    // Simultaneous events and link drop
    do_reset();
    cyc(0, 0, 8'h00, 0, 1, 0);
    cyc(1, 1, 8'h00); cyc(1, 1, 8'h00);
    cyc(1, 1, 8'h00, 0, 0, 1);
    chk("fct_plus_taken", 32'(fct_counter_p), 32'd23);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h20 + i));
    cyc(1, 0, 8'h30, 0, 1, 0);
    n0 = wr_log.size();
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h40 + i));
    cyc(1, 1, 8'h01);
    chk("eop_word", 32'(rx_data_o), 32'h100);
    cyc(1, 1, 8'h02);
    chk("eep_word", 32'(rx_data_o), 32'h101);
    chk("credit_10_writes", 32'(wr_log.size()), 32'(n0 + 10));
    cyc(1, 0, 8'h77);
    chk("credit_10_exhausted", 32'(err_credit), 32'd1);
    link_run = 1'b0;
    cyc(0, 0, 8'h00);
    chk("drop_fct_counter", 32'(fct_counter_p), 32'd0);
    chk("drop_sticky", 32'(err_credit), 32'd1);
    link_run = 1'b1;
    n0 = wr_log.size();
    cyc(1, 0, 8'h42);
    chk("drop_rx_credit_cleared", 32'(wr_log.size()), 32'(n0));

    // Reset in the middle of an escape sequence
    do_reset();
    cyc(1, 1, 8'h03);
    enable_rx = 1'b0;
    @(negedge pclk_rx);
    enable_rx = 1'b1;
    cyc(0, 0, 8'h00, 0, 1, 0);
    n0 = wr_log.size();
    cyc(1, 0, 8'h09);
    chk("midreset_no_tcode", 32'(timecode_rx_o), 32'd0);
    chk("midreset_nchar", 32'(wr_log.size()), 32'(n0 + 1));

    // Time-code sequence wrap
    do_reset();
    cyc(1, 1, 8'h03); cyc(1, 0, 8'h3F);
    cyc(1, 1, 8'h03); cyc(1, 0, 8'h00);
    chk("tick_3f_to_00", 32'(tick_out), 32'd1);
    cyc(1, 1, 8'h03); cyc(1, 0, 8'h05);
    chk("seq_tcode_value", 32'(timecode_rx_o), 32'h05);
    chk("seq_tick_05", 32'(tick_out), SEQ ? 32'd0 : 32'd1);

    repeat (2) @(negedge pclk_rx);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
